// File: rtl/limb_pkg.sv
// Shared encodings for the limb fetch/decode/execute pipeline: ALU opcodes,
// condition codes, bus transfer types and instruction field positions.
package limb_pkg;

  typedef enum logic [3:0] {
    OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  typedef enum logic [1:0] {
    TRANS_IDLE = 2'b00,
    TRANS_NSEQ = 2'b10,
    TRANS_SEQ  = 2'b11
  } trans_e;

  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_e;

  localparam int F_COND = 28;
  localparam int F_OPC  = 21;
  localparam int F_RN   = 16;
  localparam int F_RD   = 12;
  localparam int F_RS   = 8;
  localparam int F_RM   = 0;
  localparam int F_S    = 20;
  localparam int F_I    = 25;
  localparam int F_L    = 24;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] LINK_REG = 4'd14;
  localparam logic [3:0] PC_REG   = 4'd15;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond_e'(cond))
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_test_op(input alu_op_e op);
    return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    return (n == 5'd0) ? v : ((v >> n) | (v << (6'd32 - {1'b0, n})));
  endfunction

endpackage

// File: rtl/limb_alu.sv
// Combinational data-processing ALU: 32-bit wrapping adder plus logical ops,
// producing the result and the NZCV value an S-suffixed instruction would set.
module limb_alu
  import limb_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  input  logic        v_in,
  input  logic        sh_c,
  output logic [31:0] result,
  output logic [3:0]  nzcv
);

  logic [31:0] x, y, logic_res;
  logic        ci, arith;
  logic [32:0] sum;

  always_comb begin
    x         = a;
    y         = b;
    ci        = 1'b0;
    arith     = 1'b1;
    logic_res = 32'h0;
    case (op)
      OP_SUB, OP_CMP: begin y = ~b; ci = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; ci = 1'b1; end
      OP_ADD, OP_CMN: ci = 1'b0;
      OP_ADC:         ci = c_in;
      OP_SBC:         begin y = ~b; ci = c_in; end
      OP_RSC:         begin x = b; y = ~a; ci = c_in; end
      default:        arith = 1'b0;
    endcase

    case (op)
      OP_AND, OP_TST: logic_res = a & b;
      OP_EOR, OP_TEQ: logic_res = a ^ b;
      OP_ORR:         logic_res = a | b;
      OP_MOV:         logic_res = b;
      OP_BIC:         logic_res = a & ~b;
      OP_MVN:         logic_res = ~b;
      default:        logic_res = 32'h0;
    endcase

    sum    = {1'b0, x} + {1'b0, y} + {32'h0, ci};
    result = arith ? sum[31:0] : logic_res;

    nzcv[FLAG_N] = result[31];
    nzcv[FLAG_Z] = (result == 32'h0);
    nzcv[FLAG_C] = arith ? sum[32] : sh_c;
    // Overflow: operands agree in sign but the result does not.
    nzcv[FLAG_V] = arith ? ((x[31] == y[31]) && (result[31] != x[31])) : v_in;
  end

endmodule

// File: rtl/limb_pipeline.sv
// Three-stage in-order fetch/decode/execute pipeline for the limb ARMv4-subset
// core; owns PC and NZCV, fetches over the ARM7-style bus, forwards results.
module limb_pipeline
  import limb_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] addr,
  input  logic [31:0] rdata,
  input  logic        data_valid,
  output logic        write,
  output logic [1:0]  trans,
  output logic [3:0]  rr1_idx,
  output logic [3:0]  rr2_idx,
  output logic [3:0]  rr3_idx,
  input  logic [31:0] rr1,
  input  logic [31:0] rr2,
  input  logic [31:0] rr3,
  output logic        wb_en,
  output logic [3:0]  wb_idx,
  output logic [31:0] wb_data,
  output logic [3:0]  flags
);

  trans_e      trans_q;
  logic [31:0] pc, f_addr;
  logic        f_valid;
  logic        d_valid;
  logic [31:0] d_instr, d_addr;
  logic        e_valid;
  logic [31:0] e_instr, e_addr, e_a, e_b, e_s;

  logic        d_is_mul;
  logic [31:0] op1, op2_reg, op3;

  logic        ex_wb_en, ex_flag_we, ex_redirect;
  logic [3:0]  ex_wb_idx, ex_flags;
  logic [31:0] ex_wb_data, ex_target;

  logic        e_pass, e_is_mul, e_is_dp, e_is_br, e_reg_shift;
  alu_op_e     e_op;
  logic [3:0]  e_rd;
  logic [4:0]  sh_amt;
  logic [31:0] shifter_out, sh_tmp, mul_res, br_target, alu_res;
  logic        sh_c;
  logic [3:0]  alu_nzcv;

  assign addr  = pc;
  assign write = 1'b0;
  // Idle only while reset is held, so the first cycle after release is NSEQ.
  assign trans = rst ? trans_q : TRANS_IDLE;

  // ---------------- decode ----------------
  assign d_is_mul = (d_instr[27:22] == 6'd0) && (d_instr[7:4] == 4'b1001);
  assign rr1_idx  = d_is_mul ? d_instr[F_RD +: 4] : d_instr[F_RN +: 4];
  assign rr2_idx  = d_instr[F_RM +: 4];
  assign rr3_idx  = d_instr[F_RS +: 4];

  function automatic logic [31:0] resolve(
    input logic [3:0]  idx,
    input logic [31:0] rf_val,
    input logic [31:0] pc8,
    input logic        ex_we,
    input logic [3:0]  ex_idx,
    input logic [31:0] ex_val,
    input logic        wbe,
    input logic [3:0]  wbi,
    input logic [31:0] wbv
  );
    if (idx == PC_REG)                 return pc8;
    else if (ex_we && (ex_idx == idx)) return ex_val;
    else if (wbe && (wbi == idx))      return wbv;
    else                               return rf_val;
  endfunction

  always_comb begin
    op1     = resolve(rr1_idx, rr1, d_addr + 32'd8, ex_wb_en, ex_wb_idx, ex_wb_data,
                      wb_en, wb_idx, wb_data);
    op2_reg = resolve(rr2_idx, rr2, d_addr + 32'd8, ex_wb_en, ex_wb_idx, ex_wb_data,
                      wb_en, wb_idx, wb_data);
    op3     = resolve(rr3_idx, rr3, d_addr + 32'd8, ex_wb_en, ex_wb_idx, ex_wb_data,
                      wb_en, wb_idx, wb_data);
  end

  // ---------------- execute ----------------
  assign e_pass      = e_valid && cond_pass(e_instr[F_COND +: 4], flags);
  assign e_is_mul    = (e_instr[27:22] == 6'd0) && (e_instr[7:4] == 4'b1001);
  assign e_is_dp     = (e_instr[27:26] == 2'b00) && !e_is_mul;
  assign e_is_br     = (e_instr[27:25] == 3'b101);
  assign e_reg_shift = !e_instr[F_I] && e_instr[4];
  assign e_op        = alu_op_e'(e_instr[F_OPC +: 4]);
  assign e_rd        = e_instr[F_RD +: 4];
  assign sh_amt      = e_instr[11:7];
  assign sh_tmp      = e_b >> (sh_amt - 5'd1);
  assign mul_res     = (e_b * e_s) + (e_instr[21] ? e_a : 32'h0);
  assign br_target   = e_addr + 32'd8 + {{6{e_instr[23]}}, e_instr[23:0], 2'b00};

  always_comb begin
    shifter_out = e_b;
    sh_c        = flags[FLAG_C];
    if (e_instr[F_I]) begin
      shifter_out = ror32({24'h0, e_instr[7:0]}, {e_instr[11:8], 1'b0});
      sh_c        = (e_instr[11:8] == 4'd0) ? flags[FLAG_C] : shifter_out[31];
    end else begin
      // Zero amounts encode LSR/ASR #32 and RRX.
      case (shift_e'(e_instr[6:5]))
        SH_LSL: begin
          shifter_out = e_b << sh_amt;
          sh_c = (sh_amt == 5'd0) ? flags[FLAG_C] : e_b[6'd32 - {1'b0, sh_amt}];
        end
        SH_LSR: begin
          shifter_out = (sh_amt == 5'd0) ? 32'h0 : (e_b >> sh_amt);
          sh_c        = (sh_amt == 5'd0) ? e_b[31] : sh_tmp[0];
        end
        SH_ASR: begin
          shifter_out = (sh_amt == 5'd0) ? {32{e_b[31]}} : 32'($signed(e_b) >>> sh_amt);
          sh_c        = (sh_amt == 5'd0) ? e_b[31] : sh_tmp[0];
        end
        default: begin
          shifter_out = (sh_amt == 5'd0) ? {flags[FLAG_C], e_b[31:1]} : ror32(e_b, sh_amt);
          sh_c        = (sh_amt == 5'd0) ? e_b[0] : sh_tmp[0];
        end
      endcase
    end
  end

  limb_alu u_alu (
    .op     (e_op),
    .a      (e_a),
    .b      (shifter_out),
    .c_in   (flags[FLAG_C]),
    .v_in   (flags[FLAG_V]),
    .sh_c   (sh_c),
    .result (alu_res),
    .nzcv   (alu_nzcv)
  );

  always_comb begin
    ex_wb_en    = 1'b0;
    ex_wb_idx   = 4'd0;
    ex_wb_data  = 32'h0;
    ex_flag_we  = 1'b0;
    ex_flags    = flags;
    ex_redirect = 1'b0;
    ex_target   = br_target;
    if (e_pass) begin
      if (e_is_br) begin
        ex_redirect = 1'b1;
        if (e_instr[F_L]) begin
          ex_wb_en   = 1'b1;
          ex_wb_idx  = LINK_REG;
          ex_wb_data = e_addr + 32'd4;
        end
      end else if (e_is_mul) begin
        ex_wb_idx  = e_instr[F_RN +: 4];
        ex_wb_data = mul_res;
        ex_wb_en   = (ex_wb_idx != PC_REG);
        ex_flag_we = e_instr[F_S];
        ex_flags   = {mul_res[31], mul_res == 32'h0, flags[FLAG_C], flags[FLAG_V]};
      end else if (e_is_dp && !e_reg_shift) begin
        if ((e_rd == PC_REG) && !is_test_op(e_op)) begin
          ex_redirect = 1'b1;
          ex_target   = alu_res;
        end else begin
          ex_wb_en   = !is_test_op(e_op);
          ex_wb_idx  = e_rd;
          ex_wb_data = alu_res;
          ex_flag_we = e_instr[F_S];
          ex_flags   = alu_nzcv;
        end
      end
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      trans_q <= TRANS_NSEQ;
      f_valid <= 1'b0;
      f_addr  <= 32'h0;
      d_valid <= 1'b0;
      d_instr <= 32'h0;
      d_addr  <= 32'h0;
      e_valid <= 1'b0;
      e_instr <= 32'h0;
      e_addr  <= 32'h0;
      e_a     <= 32'h0;
      e_b     <= 32'h0;
      e_s     <= 32'h0;
      wb_en   <= 1'b0;
      wb_idx  <= 4'd0;
      wb_data <= 32'h0;
      flags   <= 4'h0;
    end else begin
      f_addr  <= pc;
      e_instr <= d_instr;
      e_addr  <= d_addr;
      e_a     <= op1;
      e_b     <= op2_reg;
      e_s     <= op3;
      if (f_valid && data_valid) begin
        d_instr <= rdata;
        d_addr  <= f_addr;
      end
      // A redirect also drops the response to the fetch issued this cycle.
      if (ex_redirect) begin
        pc      <= ex_target;
        trans_q <= TRANS_NSEQ;
        f_valid <= 1'b0;
        d_valid <= 1'b0;
        e_valid <= 1'b0;
      end else begin
        pc      <= pc + 32'd4;
        trans_q <= TRANS_SEQ;
        f_valid <= 1'b1;
        d_valid <= f_valid && data_valid;
        e_valid <= d_valid;
      end
      wb_en <= ex_wb_en;
      if (ex_wb_en) begin
        wb_idx  <= ex_wb_idx;
        wb_data <= ex_wb_data;
      end
      if (ex_flag_we) flags <= ex_flags;
    end
  end

endmodule

// File: tb/tb_limb_pipeline.sv
// Directed bench for limb_pipeline: small program in a bus memory model,
// register file model, cycle-by-cycle checks and a mid-redirect reset.
module tb_limb_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr, rdata;
  logic        data_valid;
  logic        write;
  logic [1:0]  trans;
  logic [3:0]  rr1_idx, rr2_idx, rr3_idx;
  logic [31:0] rr1, rr2, rr3;
  logic        wb_en;
  logic [3:0]  wb_idx;
  logic [31:0] wb_data;
  logic [3:0]  flags;

  logic [31:0] rf [16];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  limb_pipeline #(.RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .rdata      (rdata),
    .data_valid (data_valid),
    .write      (write),
    .trans      (trans),
    .rr1_idx    (rr1_idx),
    .rr2_idx    (rr2_idx),
    .rr3_idx    (rr3_idx),
    .rr1        (rr1),
    .rr2        (rr2),
    .rr3        (rr3),
    .wb_en      (wb_en),
    .wb_idx     (wb_idx),
    .wb_data    (wb_data),
    .flags      (flags)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h00: return 32'hE3A014FF;  // MOV   r1,#0xFF000000
      32'h04: return 32'hE0912001;  // ADDS  r2,r1,r1
      32'h08: return 32'hE1500000;  // CMP   r0,r0
      32'h0C: return 32'h12803001;  // ADDNE r3,r0,#1
      32'h10: return 32'hEB000002;  // BL    0x20
      32'h14: return 32'hE3A06001;  // MOV   r6,#1   (shadow)
      32'h18: return 32'hE3A07002;  // MOV   r7,#2   (shadow)
      32'h1C: return 32'hE3A08003;  // MOV   r8,#3   (dropped)
      32'h20: return 32'hE3A02003;  // MOV   r2,#3
      32'h24: return 32'hE3A03007;  // MOV   r3,#7
      32'h28: return 32'hE3A0500A;  // MOV   r5,#10
      32'h2C: return 32'hE0245392;  // MLA   r4,r2,r3,r5
      32'h30: return 32'hE052A003;  // SUBS  r10,r2,r3
      32'h34: return 32'hEAFFFFFE;  // B     .
      default: return 32'hF0000000; // NV: nop
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_valid <= 1'b0;
      rdata      <= 32'h0;
    end else begin
      data_valid <= (trans != 2'b00);
      rdata      <= imem(addr);
    end
  end

  initial for (int i = 0; i < 16; i++) rf[i] = 32'h0;
  always @(posedge clk) if (wb_en) rf[wb_idx] <= wb_data;

  assign rr1 = rf[rr1_idx];
  assign rr2 = rf[rr2_idx];
  assign rr3 = rf[rr3_idx];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic chk_wb(input int c, input logic [3:0] idx, input logic [31:0] data);
    chk($sformatf("c%0d wb_en", c), {31'h0, wb_en}, 32'd1);
    chk($sformatf("c%0d wb_idx", c), {28'h0, wb_idx}, {28'h0, idx});
    chk($sformatf("c%0d wb_data", c), wb_data, data);
  endtask

  task automatic chk_nowb(input int c);
    chk($sformatf("c%0d wb_en", c), {31'h0, wb_en}, 32'd0);
  endtask

  task automatic chk_fetch(input int c, input logic [31:0] a, input logic [1:0] t);
    chk($sformatf("c%0d addr", c), addr, a);
    chk($sformatf("c%0d trans", c), {30'h0, trans}, {30'h0, t});
  endtask

  task automatic chk_flags(input int c, input logic [3:0] f);
    chk($sformatf("c%0d flags", c), {28'h0, flags}, {28'h0, f});
  endtask

  // Cycle 0 is the first cycle after reset release.
  task automatic check_cycle(input int c);
    case (c)
      0:  begin chk_fetch(c, 32'h00, 2'b10); chk_nowb(c); chk_flags(c, 4'h0); end
      1:  begin chk_fetch(c, 32'h04, 2'b11); chk_nowb(c); end
      2:  begin chk_fetch(c, 32'h08, 2'b11); chk_nowb(c); end
      3:  chk_nowb(c);
      4:  chk_wb(c, 4'd1, 32'hFF000000);
      5:  begin chk_wb(c, 4'd2, 32'hFE000000); chk_flags(c, 4'b1010); end
      6:  begin chk_nowb(c); chk_flags(c, 4'b0110); end
      7:  chk_nowb(c);
      8:  begin chk_wb(c, 4'd14, 32'h14); chk_fetch(c, 32'h20, 2'b10); end
      9:  begin chk_nowb(c); chk_fetch(c, 32'h24, 2'b11); end
      10: chk_nowb(c);
      11: chk_nowb(c);
      12: chk_wb(c, 4'd2, 32'd3);
      13: chk_wb(c, 4'd3, 32'd7);
      14: chk_wb(c, 4'd5, 32'd10);
      15: begin chk_wb(c, 4'd4, 32'd31); chk_flags(c, 4'b0110); end
      16: begin chk_wb(c, 4'd10, 32'hFFFFFFFC); chk_flags(c, 4'b1000);
                chk_fetch(c, 32'h40, 2'b11); end
      17: begin chk_nowb(c); chk_fetch(c, 32'h34, 2'b10); end
      18: chk_fetch(c, 32'h38, 2'b11);
      default: chk_nowb(c);
    endcase
  endtask

  task automatic run_program(input int last);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_cycle(0);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      #1;
      check_cycle(c);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst addr", addr, 32'h0);
    chk("rst trans", {30'h0, trans}, 32'h0);
    chk("rst wb_en", {31'h0, wb_en}, 32'h0);
    chk("rst write", {31'h0, write}, 32'h0);

    run_program(20);

    // Cycle 20: the B . at 0x34 is in execute with its redirect pending.
    #2;
    rst = 1'b0;
    #1;
    chk("midrst addr", addr, 32'h0);
    chk("midrst trans", {30'h0, trans}, 32'h0);
    chk("midrst wb_en", {31'h0, wb_en}, 32'h0);
    chk("midrst wb_idx", {28'h0, wb_idx}, 32'h0);
    chk("midrst wb_data", wb_data, 32'h0);
    chk("midrst flags", {28'h0, flags}, 32'h0);
    repeat (2) @(posedge clk);

    run_program(17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/limb_pipeline.md
Name: limb_pipeline

Overview:
Three-stage in-order fetch/decode/execute pipeline for the limb ARM-style core (ARMv4 subset).
- Owns the PC and NZCV flags.
- Fetches over the ARM7-style memory bus.
- Reads the external register file through combinational read ports.
- Presents register writebacks to an external writeback stage and register file.

Parameters:
RESET_PC, 32'h0, fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
addr  out  32  fetch address
rdata  in  32  fetched instruction (valid when data_valid=1)
data_valid  in  1  rdata carries the instruction requested on the previous cycle
write  out  1  always 0 (loads/stores not supported)
trans  out  2  00 idle, 10 non-sequential, 11 sequential
rr1_idx, rr2_idx, rr3_idx  out  4 each  register-file read indices (Rn, Rm, Rs)
rr1, rr2, rr3  in  32 each  combinational read data
wb_en  out  1  writeback valid
wb_idx  out  4  destination register (0-14)
wb_data  out  32  writeback value
flags  out  4  NZCV

Behaviour:
- Reset (async, rst=0): addr=RESET_PC, trans=00, wb_en=0, wb_idx=0, wb_data=0, flags=0, decode/execute invalid, write=0.
- Fetch:
  - First cycle after release: trans=10. Thereafter trans=11; 10 again after each redirect.
  - pc advances by 4 every cycle.
  - The instruction at pc is captured into decode on the following edge if data_valid=1; its address is kept with it.
- Redirect: a taken branch or PC write in execute sets pc<=target, invalidates decode/execute, and discards the one in-flight response. The two sequential instructions after the branch never execute.
- Decode:
  - Drives rr*_idx from the instruction fields.
  - Reading R15 yields instruction address+8.
  - Forwarding priority: the current execute-stage result, then wb outputs, then the register file.
  - Latches operands, opcode and condition into execute.
- Execute (single cycle) evaluates the condition against flags:
  - EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL.
  - NV (1111) executes as a NOP.
  - A failed condition is a NOP.
  - Results are registered onto wb_* at the edge.
  - wb_en stays high one cycle per writing instruction, otherwise 0.
- Data processing ([27:26]=00, not the multiply pattern):
  - Opcodes 0-15: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN.
  - Immediate operand2: imm8 ROR 2*rot. Shifter carry is the old C when rot=0, else bit31 of the result.
  - Register operand2: Rm shifted by imm5 (LSL/LSR/ASR/ROR with ARM encodings: LSR/ASR #0 means 32, ROR #0 means RRX).
  - Register-specified shifts ([4]=1) execute as NOP.
  - S=1: N,Z from the result. C from the adder for arithmetic ops, from the shifter for logical ops. V from the adder for arithmetic ops only.
  - TST/TEQ/CMP/CMN write flags, never wb.
  - Rd=15: redirect to the result; no wb, no flag update.
- Multiply ([27:22]=0, [7:4]=1001):
  - MUL Rd[19:16]=Rm*Rs, low 32 bits.
  - MLA adds Rn[15:12].
  - S updates N,Z; C,V unchanged.
- Branch ([27:25]=101):
  - Target = address+8 + sign-extended imm24<<2.
  - BL also writes R14 = address+4.
- All other encodings: NOP.
- Arithmetic is 32-bit, wrapping.
- Reset mid-operation: all in-flight instructions are dropped and fetch restarts at RESET_PC.

Decomposition:
- Package limb_pkg: opcode and condition enumerations, trans encodings, instruction field positions.
- Sub-module limb_alu: opcode, a, b, carry-in and shifter-carry in; result and NZCV out. It is combinational.

Test Plan:
- Reset release with RESET_PC=0 → addr 0,4,8 on successive cycles; trans 10 then 11; wb_en=0 until the first instruction executes.
- MOV r1,#0xFF000000 (imm rot) then ADDS r2,r1,r1 → wb r1=FF000000, then wb r2=FE000000 using forwarding; flags N=1 C=1 Z=0 V=0.
- CMP r0,r0 then ADDNE r3,r0,#1 → Z=1; no wb for the ADDNE.
- MLA r4,r2,r3,r5 with r2=3, r3=7, r5=10 → wb r4=31.
- BL +8 at address 0x10 → wb r14=0x14; next addr 0x20 with trans=10; instructions at 0x14 and 0x18 produce no wb.
- Assert rst during a branch redirect → outputs return to reset values immediately; fetch restarts at RESET_PC.
